// File: rtl/keypad_scan_4x4_if.sv
// Keypad-side and key-output signals of the 4x4 scanner, bundled for port hookup.
// master = scanner, slave = keypad/consumer side.
interface keypad_scan_4x4_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_event;

  modport master (
    input  row_in,
    output col_out,
    output key_valid,
    output key_code,
    output key_event
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_valid,
    input  key_code,
    input  key_event
  );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized active-low rows,
// single-key frame detection and frame-count debounce with a held key code.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV   = 100_000,
  parameter int DEB_FRAMES = 10
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  keypad_scan_4x4_if.master kp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEB_FRAMES);
  // Frame results and the candidate are {is_key, code}; NONE keeps code zero so compares are exact.
  localparam logic [4:0]    RES_NONE   = 5'b0_0000;

  logic [3:0]    row_meta_reg;
  logic [3:0]    row_sync_reg;
  logic [CW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  logic [3:0]    col_out_reg;
  logic [1:0]    hits_reg;
  logic [1:0]    hit_row_reg;
  logic [1:0]    hit_col_reg;
  logic [4:0]    cand_reg;
  logic [SW-1:0] stable_reg;
  logic          key_valid_reg;
  logic [3:0]    key_code_reg;
  logic          key_event_reg;

  logic [1:0]    col_idx_next;
  logic [3:0]    col_out_next;
  logic [2:0]    low_cnt;
  logic [1:0]    low_row;
  logic [2:0]    hits_sum;
  logic [1:0]    hits_next;
  logic [4:0]    frame_res;
  logic [SW-1:0] stable_next;
  logic          accept;
  logic          sample;
  logic          frame_end;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign col_idx_next = col_idx_reg + 2'd1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_out_next[gi] = (col_idx_next != 2'(gi));
    end
  endgenerate

  assign sample    = (dwell_reg == DWELL_LAST);
  assign frame_end = sample && (col_idx_reg == 2'd3);

  always_comb begin
    low_cnt = 3'd0;
    low_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_reg[r]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(r);
      end
    end
  end

  // Hit count saturates at 2: anything beyond one low bit per frame means "reject".
  always_comb begin
    hits_sum  = {1'b0, hits_reg} + low_cnt;
    hits_next = (hits_sum > 3'd1) ? 2'd2 : hits_sum[1:0];
    frame_res = RES_NONE;
    if (hits_sum == 3'd1) begin
      if (hits_reg == 2'd1) frame_res = {1'b1, key_map(hit_row_reg, hit_col_reg)};
      else                  frame_res = {1'b1, key_map(low_row, col_idx_reg)};
    end
  end

  always_comb begin
    stable_next = stable_reg;
    accept      = 1'b0;
    if (frame_res != cand_reg) begin
      stable_next = SW'(1);
      accept      = (DEB_FRAMES == 1);
    end else if (stable_reg < STABLE_MAX) begin
      stable_next = stable_reg + SW'(1);
      accept      = ((stable_reg + SW'(1)) == STABLE_MAX);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta_reg  <= 4'hF;
      row_sync_reg  <= 4'hF;
      dwell_reg     <= '0;
      col_idx_reg   <= 2'd0;
      col_out_reg   <= 4'b1110;
      hits_reg      <= 2'd0;
      hit_row_reg   <= 2'd0;
      hit_col_reg   <= 2'd0;
      cand_reg      <= RES_NONE;
      stable_reg    <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      key_event_reg <= 1'b0;
    end else begin
      row_meta_reg  <= kp.row_in;
      row_sync_reg  <= row_meta_reg;
      key_event_reg <= 1'b0;
      if (sample) begin
        dwell_reg   <= '0;
        col_idx_reg <= col_idx_next;
        col_out_reg <= col_out_next;
        if (frame_end) begin
          hits_reg   <= 2'd0;
          cand_reg   <= frame_res;
          stable_reg <= stable_next;
          if (accept) begin
            if (frame_res[4]) begin
              key_valid_reg <= 1'b1;
              key_code_reg  <= frame_res[3:0];
              key_event_reg <= !key_valid_reg || (key_code_reg != frame_res[3:0]);
            end else begin
              key_valid_reg <= 1'b0;
            end
          end
        end else begin
          hits_reg <= hits_next;
          if (hits_reg == 2'd0 && low_cnt == 3'd1) begin
            hit_row_reg <= low_row;
            hit_col_reg <= col_idx_reg;
          end
        end
      end else begin
        dwell_reg <= dwell_reg + CW'(1);
      end
    end
  end

  assign kp.col_out   = col_out_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_code  = key_code_reg;
  assign kp.key_event = key_event_reg;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: keypad matrix model, frame-level reference model checked
// every cycle, directed scenarios followed by randomized key patterns.
module tb_keypad_scan_4x4;
  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [15:0] pressed = '0;   // bit r*4+c = key (row r, column c) held down
  logic [3:0]  rows_v;

  int total = 0;
  int bad   = 0;
  int ev_seen = 0;
  int edges = 0;

  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_4x4_if kp_if();

  keypad_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .kp        (kp_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_if.col_out[c]) rows_v[r] = 1'b0;
  end
  assign kp_if.row_in = rows_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model: the key set each column sample sees is the set held two clocks
  // before that sample (row synchronizer); frame rules and debounce from the key rules.
  int          m_edge, m_hits, m_code, m_cand, m_stable, exp_code, exp_col;
  bit          exp_valid, exp_event;
  logic [15:0] m_d1, m_d2;

  task automatic model_reset();
    m_edge = 0; m_hits = 0; m_code = 0; m_cand = -1; m_stable = 0;
    m_d1 = '0; m_d2 = '0;
    exp_valid = 0; exp_code = 0; exp_event = 0; exp_col = 0;
  endtask

  task automatic model_edge();
    logic [15:0] seen;
    int c, res;
    bit acc;
    seen = m_d2; m_d2 = m_d1; m_d1 = pressed;
    exp_event = 0;
    if (m_edge % SCAN_DIV == SCAN_DIV - 1) begin
      c = (m_edge / SCAN_DIV) % 4;
      for (int r = 0; r < 4; r++)
        if (seen[r*4+c]) begin
          m_hits++;
          m_code = int'(key_tab[r*4+c]);
        end
    end
    if (m_edge % FRAME == FRAME - 1) begin
      res = (m_hits == 1) ? m_code : -1;
      m_hits = 0;
      acc = 0;
      if (res != m_cand) begin
        m_cand = res; m_stable = 1; acc = (DEB == 1);
      end else if (m_stable < DEB) begin
        m_stable++; acc = (m_stable == DEB);
      end
      if (acc) begin
        if (res < 0) exp_valid = 0;
        else begin
          exp_event = !exp_valid || (exp_code != res);
          exp_valid = 1;
          exp_code  = res;
        end
      end
    end
    m_edge++;
    exp_col = (m_edge / SCAN_DIV) % 4;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    logic [3:0] exp_col_bits;
    forever begin
      @(negedge clk);
      exp_col_bits = ~(4'b0001 << exp_col);
      check("col_out",   kp_if.col_out,   exp_col_bits);
      check("key_valid", kp_if.key_valid, exp_valid);
      check("key_code",  kp_if.key_code,  exp_code);
      check("key_event", kp_if.key_event, exp_event);
      if (kp_if.key_event) ev_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic to_frame_start();
    while (edges % FRAME != 0) step(1);
  endtask

  task automatic pulse_reset(input int n);
    sys_rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    sys_rst_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    int ev0;
    int kind, hold, a, b;
    logic [15:0] p;

    // reset and column rotation
    #1 sys_rst_n = 1'b0;
    #2;
    check("rst_col", kp_if.col_out, 4'b1110);
    check("rst_valid", kp_if.key_valid, 1'b0);
    check("rst_code", kp_if.key_code, 4'h0);
    check("rst_event", kp_if.key_event, 1'b0);
    @(posedge clk); #1;
    pulse_reset(3);
    check("rot0", kp_if.col_out, 4'b1110);
    step(8);  check("rot1", kp_if.col_out, 4'b1101);
    step(8);  check("rot2", kp_if.col_out, 4'b1011);
    step(8);  check("rot3", kp_if.col_out, 4'b0111);
    step(8);  check("rot4", kp_if.col_out, 4'b1110);
    $display("scenario reset/rotation edges=%0d", edges);

    // clean press r1c2 from a frame start
    ev0 = ev_seen;
    pressed = 16'h0040;
    step(3*FRAME - 1);
    check("p6_early_valid", kp_if.key_valid, 1'b0);
    check("p6_early_events", ev_seen - ev0, 0);
    step(1);
    check("p6_valid", kp_if.key_valid, 1'b1);
    check("p6_code", kp_if.key_code, 4'h6);
    check("p6_event", kp_if.key_event, 1'b1);
    step(1);
    check("p6_event_once", kp_if.key_event, 1'b0);
    $display("scenario press 6 code=%h", kp_if.key_code);

    // release after '6'
    to_frame_start();
    ev0 = ev_seen;
    pressed = '0;
    step(3*FRAME - 1);
    check("rel_still_valid", kp_if.key_valid, 1'b1);
    step(1);
    check("rel_valid", kp_if.key_valid, 1'b0);
    check("rel_code_held", kp_if.key_code, 4'h6);
    step(2);
    check("rel_no_event", ev_seen - ev0, 0);
    $display("scenario release valid=%0b code=%h", kp_if.key_valid, kp_if.key_code);

    // press r2c2 -> '9'
    to_frame_start();
    ev0 = ev_seen;
    pressed = 16'h0400;
    step(3*FRAME);
    check("p9_valid", kp_if.key_valid, 1'b1);
    check("p9_code", kp_if.key_code, 4'h9);
    step(2);
    check("p9_events", ev_seen - ev0, 1);
    $display("scenario press 9 code=%h", kp_if.key_code);

    // bounce on r0c3, then hold
    pressed = '0;
    step(4*FRAME);
    to_frame_start();
    ev0 = ev_seen;
    pressed = 16'h0008;
    for (int i = 0; i < 10; i++) begin
      step(20);
      pressed = pressed ^ 16'h0008;
    end
    check("bounce_no_event", ev_seen - ev0, 0);
    check("bounce_no_valid", kp_if.key_valid, 1'b0);
    step(4*FRAME);
    check("bounce_valid", kp_if.key_valid, 1'b1);
    check("bounce_code", kp_if.key_code, 4'hA);
    check("bounce_events", ev_seen - ev0, 1);
    $display("scenario bounce code=%h", kp_if.key_code);

    // two keys in one column, then one released
    pressed = '0;
    step(4*FRAME);
    to_frame_start();
    ev0 = ev_seen;
    pressed = 16'h0101;
    step(5*FRAME);
    check("multi_valid", kp_if.key_valid, 1'b0);
    check("multi_no_event", ev_seen - ev0, 0);
    pressed = 16'h0001;
    step(3*FRAME);
    check("multi_rel_valid", kp_if.key_valid, 1'b1);
    check("multi_rel_code", kp_if.key_code, 4'h1);
    step(1);
    check("multi_rel_events", ev_seen - ev0, 1);
    $display("scenario multi-key code=%h", kp_if.key_code);

    // reset while '5' is held and accepted
    pressed = 16'h0020;
    step(4*FRAME);
    check("p5_code", kp_if.key_code, 4'h5);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", kp_if.key_valid, 1'b0);
    check("mid_rst_code", kp_if.key_code, 4'h0);
    check("mid_rst_col", kp_if.col_out, 4'b1110);
    @(posedge clk); #1;
    pulse_reset(2);
    step(3*FRAME - 1);
    check("re5_early_valid", kp_if.key_valid, 1'b0);
    step(1);
    check("re5_valid", kp_if.key_valid, 1'b1);
    check("re5_code", kp_if.key_code, 4'h5);
    check("re5_event", kp_if.key_event, 1'b1);
    $display("scenario reset mid-press code=%h", kp_if.key_code);

    // randomized key patterns; the reference model checks every cycle
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(20, 140));
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      p = '0;
      if (kind >= 2 && kind < 7) p = 16'(1) << a;
      else if (kind >= 7) p = (16'(1) << a) | (16'(1) << b);
      if (kind == 9) begin
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
          pressed = p ^ (16'(1) << a);
          step(int'($urandom_range(1, 25)));
          pressed = p;
          step(int'($urandom_range(1, 25)));
        end
      end
      pressed = p;
      if ($urandom_range(0, 15) == 0) pulse_reset(2);
      step(hold);
      $display("txn %0d keys=%h hold=%0d valid=%0b code=%h events=%0d",
               t, p, hold, kp_if.key_valid, kp_if.key_code, ev_seen);
    end

    pressed = '0;
    step(4*FRAME);
    check("final_valid", kp_if.key_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
